// File: rtl/neuron_feeder.sv
`default_nettype none
// ============================================================================
// Module   : neuron_feeder
// Purpose  : Upstream sequencer for a single time-multiplexed MAC neuron.
//            For each of NEURONS weight rows it clears the neuron
//            accumulator and streams x[0..SIZE-1] with weight row n from
//            synchronous-read memories into the neuron.  It then captures
//            the neuron result and offers it on a valid/ready handshake.
//            Each start runs one full layer pass.
// Ports    : clk, rst (async, active-high)
//            start / busy / done        - pass control and status
//            x_addr, x_data             - x memory (1-cycle read latency)
//            w_addr, w_data             - weight memory, row-major n*SIZE+i
//            mac_x, mac_w, mac_clr      - drive to the neuron
//            mac_y                      - neuron accumulator output
//            out_valid/out_ready/out_data/out_idx - result handshake
//            b_addr, b_data             - bias memory (NEURON_FEEDER_BIAS_EN)
// Options  : NEURON_FEEDER_BIAS_EN - adds one bias term per row.
//            The bias term is presented as mac_x=1, mac_w=b[n].
// Revision : 1.0 - initial release
// ============================================================================
module neuron_feeder #(
  parameter int SIZE     = 16,
  parameter int NEURONS  = 8,
  parameter int BIT_SIZE = 16,
  parameter int X_ADDR_W = (SIZE > 1) ? $clog2(SIZE) : 1,
  parameter int W_ADDR_W = (SIZE * NEURONS > 1) ? $clog2(SIZE * NEURONS) : 1,
  parameter int IDX_W    = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [X_ADDR_W-1:0] x_addr,
  input  logic [BIT_SIZE-1:0] x_data,
  output logic [W_ADDR_W-1:0] w_addr,
  input  logic [BIT_SIZE-1:0] w_data,
`ifdef NEURON_FEEDER_BIAS_EN
  output logic [IDX_W-1:0]    b_addr,
  input  logic [BIT_SIZE-1:0] b_data,
`endif
  output logic [BIT_SIZE-1:0] mac_x,
  output logic [BIT_SIZE-1:0] mac_w,
  output logic                mac_clr,
  input  logic [BIT_SIZE-1:0] mac_y,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BIT_SIZE-1:0] out_data,
  output logic [IDX_W-1:0]    out_idx
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_CLEAR  = 3'd1;
  localparam logic [2:0] c_STREAM = 3'd2;
  localparam logic [2:0] c_DRAIN  = 3'd3;
  localparam logic [2:0] c_OUTPUT = 3'd4;

  localparam logic [X_ADDR_W-1:0] c_I_LAST   = X_ADDR_W'(SIZE - 1);
  localparam logic [IDX_W-1:0]    c_N_LAST   = IDX_W'(NEURONS - 1);
  localparam logic [W_ADDR_W-1:0] c_ROW_STEP = W_ADDR_W'(SIZE);

  logic [2:0]          r_state;
  logic [2:0]          w_next_state;
  logic [X_ADDR_W-1:0] r_i;
  logic [IDX_W-1:0]    r_n;
  logic [W_ADDR_W-1:0] r_row_base;
  logic [W_ADDR_W-1:0] r_w_addr;
  logic                r_vld;
  logic                r_out_valid;
  logic [BIT_SIZE-1:0] r_out_data;
  logic [IDX_W-1:0]    r_out_idx;
  logic                r_done;
  logic                w_stream_last;
  logic                w_handshake;
  logic                w_last_row;
`ifdef NEURON_FEEDER_BIAS_EN
  logic                r_bias_phase;
  logic                r_bias_vld;
`endif

  assign x_addr    = r_i;
  assign w_addr    = r_w_addr;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_idx   = r_out_idx;
  assign done      = r_done;
`ifdef NEURON_FEEDER_BIAS_EN
  // Bias address is simply the current row; it is read during the bias
  // cycle at the head of STREAM.
  assign b_addr    = r_n;
  assign w_stream_last = !r_bias_phase && (r_i == c_I_LAST);
`else
  assign w_stream_last = (r_i == c_I_LAST);
`endif
  assign w_handshake = r_out_valid && out_ready;
  assign w_last_row  = (r_n == c_N_LAST);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:   if (start) w_next_state = c_CLEAR;
      c_CLEAR:  w_next_state = c_STREAM;
      c_STREAM: if (w_stream_last) w_next_state = c_DRAIN;
      c_DRAIN:  w_next_state = c_OUTPUT;
      c_OUTPUT: if (w_handshake) w_next_state = w_last_row ? c_IDLE : c_CLEAR;
      default:  w_next_state = c_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic. Memory data arrives one cycle after its address, so the
  // neuron inputs are gated by flags registered one cycle behind address
  // issue; outside those cycles the neuron sees a zero product.
  // --------------------------------------------------------------------------
  always_comb begin
    busy    = (r_state != c_IDLE);
    mac_clr = (r_state == c_CLEAR);
    mac_x   = '0;
    mac_w   = '0;
    if (r_vld) begin
      mac_x = x_data;
      mac_w = w_data;
    end
`ifdef NEURON_FEEDER_BIAS_EN
    if (r_bias_vld) begin
      mac_x = BIT_SIZE'(1);
      mac_w = b_data;
    end
`endif
  end

  // --------------------------------------------------------------------------
  // Counters, addresses and result capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_i          <= '0;
      r_n          <= '0;
      r_row_base   <= '0;
      r_w_addr     <= '0;
      r_vld        <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_idx    <= '0;
      r_done       <= 1'b0;
`ifdef NEURON_FEEDER_BIAS_EN
      r_bias_phase <= 1'b0;
      r_bias_vld   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef NEURON_FEEDER_BIAS_EN
      r_vld      <= (r_state == c_STREAM) && !r_bias_phase;
      r_bias_vld <= (r_state == c_STREAM) &&  r_bias_phase;
`else
      r_vld      <= (r_state == c_STREAM);
`endif
      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_n        <= '0;
            r_row_base <= '0;
          end
        end
        c_CLEAR: begin
          r_i      <= '0;
          r_w_addr <= r_row_base;
`ifdef NEURON_FEEDER_BIAS_EN
          r_bias_phase <= 1'b1;
`endif
        end
        c_STREAM: begin
`ifdef NEURON_FEEDER_BIAS_EN
          if (r_bias_phase) begin
            r_bias_phase <= 1'b0;
          end else if (r_i != c_I_LAST) begin
            r_i      <= r_i + 1'b1;
            r_w_addr <= r_w_addr + 1'b1;
          end
`else
          // Addresses stop at the last term and stay frozen until the
          // next row is set up in CLEAR.
          if (r_i != c_I_LAST) begin
            r_i      <= r_i + 1'b1;
            r_w_addr <= r_w_addr + 1'b1;
          end
`endif
        end
        c_DRAIN: begin
          // The last term was accumulated on the negedge inside DRAIN,
          // so mac_y is final here.
          r_out_data  <= mac_y;
          r_out_idx   <= r_n;
          r_out_valid <= 1'b1;
        end
        c_OUTPUT: begin
          if (w_handshake) begin
            r_out_valid <= 1'b0;
            if (w_last_row) begin
              r_done <= 1'b1;
            end else begin
              r_n        <= r_n + 1'b1;
              r_row_base <= r_row_base + c_ROW_STEP;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_neuron_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_neuron_feeder
// Purpose  : Self-checking bench for neuron_feeder with behavioural memories
//            and a saturating negedge neuron; results are compared against
//            a dot-product reference computed from the memory contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_neuron_feeder;
  localparam int SIZE    = 4;
  localparam int NEURONS = 2;
  localparam int BW      = 16;
  localparam int XAW     = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int WAW     = (SIZE * NEURONS > 1) ? $clog2(SIZE * NEURONS) : 1;
  localparam int IW      = (NEURONS > 1) ? $clog2(NEURONS) : 1;
`ifdef NEURON_FEEDER_BIAS_EN
  localparam int EXTRA   = 1;
`else
  localparam int EXTRA   = 0;
`endif
  localparam int LAT     = SIZE + 2 + EXTRA;

  logic           clk = 1'b0;
  logic           rst, start, busy, done, mac_clr, out_valid, out_ready;
  logic [XAW-1:0] x_addr;
  logic [WAW-1:0] w_addr;
  logic [BW-1:0]  x_data, w_data, mac_x, mac_w, mac_y, out_data;
  logic [IW-1:0]  out_idx;
`ifdef NEURON_FEEDER_BIAS_EN
  logic [IW-1:0]  b_addr;
  logic [BW-1:0]  b_data;
`endif

  logic signed [BW-1:0] x_mem [SIZE];
  logic signed [BW-1:0] w_mem [SIZE*NEURONS];
  logic signed [BW-1:0] b_mem [NEURONS];

  int total    = 0;
  int bad      = 0;
  int done_cnt = 0;
  int acc      = 0;

  always #5 clk = ~clk;

  neuron_feeder #(.SIZE(SIZE), .NEURONS(NEURONS), .BIT_SIZE(BW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .x_addr(x_addr), .x_data(x_data), .w_addr(w_addr), .w_data(w_data),
`ifdef NEURON_FEEDER_BIAS_EN
    .b_addr(b_addr), .b_data(b_data),
`endif
    .mac_x(mac_x), .mac_w(mac_w), .mac_clr(mac_clr), .mac_y(mac_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx)
  );

  // Synchronous-read memories
  always @(posedge clk) begin
    x_data <= x_mem[x_addr];
    w_data <= w_mem[w_addr];
`ifdef NEURON_FEEDER_BIAS_EN
    b_data <= b_mem[b_addr];
`endif
  end

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Neuron: saturating accumulate on negedge, cleared by rst or mac_clr
  always @(negedge clk or posedge rst) begin
    if (rst) acc <= 0;
    else if (mac_clr) acc <= 0;
    else acc <= sat16(acc + int'($signed(mac_x)) * int'($signed(mac_w)));
  end
  assign mac_y = BW'(acc);

  always @(negedge clk) if (done) done_cnt++;

  // Reference: saturating dot product of x with weight row n (bias first)
  function automatic logic [BW-1:0] ref_row(input int n);
    int a = 0;
`ifdef NEURON_FEEDER_BIAS_EN
    a = sat16(a + int'(b_mem[n]));
`endif
    for (int i = 0; i < SIZE; i++)
      a = sat16(a + int'(x_mem[i]) * int'(w_mem[n*SIZE+i]));
    return BW'(a);
  endfunction

  function automatic logic [BW-1:0] rand_val();
    if ($urandom_range(0, 7) == 0) return BW'($urandom);
    return BW'(int'($urandom_range(0, 255)) - 128);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_directed(input bit satur);
    for (int i = 0; i < SIZE; i++) x_mem[i] = BW'(i + 1);
    for (int i = 0; i < SIZE; i++) w_mem[i] = 16'sd1;
    w_mem[SIZE+0] = 16'sd2; w_mem[SIZE+1] = 16'sd0;
    w_mem[SIZE+2] = -16'sd1; w_mem[SIZE+3] = 16'sd1;
    b_mem[0] = 16'sd5; b_mem[1] = -16'sd3;
    if (satur) begin
      x_mem[0] = 16'sd100; x_mem[1] = 16'sd100; x_mem[2] = 16'sd0; x_mem[3] = 16'sd0;
      w_mem[0] = 16'sd300; w_mem[1] = 16'sd300; w_mem[2] = 16'sd0; w_mem[3] = 16'sd0;
    end
  endtask

  // One layer pass. bp0: hold cycles on row 0; rnd: random hold on later
  // rows; poke: toggle start while busy and on the final handshake edge.
  task automatic run_pass(input int bp0, input bit rnd, input bit poke);
    logic [BW-1:0]  exp_y [NEURONS];
    logic [XAW-1:0] xa_h;
    logic [WAW-1:0] wa_h;
    int  got = 0, cyc = 0, hs_edge = 0, wait_cnt = 0, hold_target = 0, d0;
    bit  seen = 1'b0;
    for (int n = 0; n < NEURONS; n++) exp_y[n] = ref_row(n);
    d0 = done_cnt;
    xa_h = '0;
    wa_h = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("clear_state", {30'd0, busy, mac_clr}, 32'd3);
    chk("clear_mac_zero", {mac_x, mac_w}, 32'd0);
    while (got < NEURONS && cyc < 400) begin
      if (poke) start = 1'($urandom_range(0, 1));
      if (out_valid) begin
        if (!seen) begin
          seen = 1'b1;
          chk("row_latency", cyc - hs_edge, LAT);
          hold_target = (got == 0) ? bp0 : (rnd ? int'($urandom_range(0, 3)) : 0);
          wait_cnt = 0;
          xa_h = x_addr;
          wa_h = w_addr;
        end
        if (wait_cnt < hold_target) begin
          out_ready = 1'b0;
          wait_cnt++;
          chk("hold_data", out_data, exp_y[got]);
          chk("hold_idx", out_idx, got);
          chk("hold_addr", {x_addr, w_addr}, {xa_h, wa_h});
          chk("hold_mac_zero", {mac_x, mac_w}, 32'd0);
          chk("hold_status", {30'd0, busy, mac_clr}, 32'd2);
        end else begin
          out_ready = 1'b1;
          chk("out_data", out_data, exp_y[got]);
          chk("out_idx", out_idx, got);
          chk("done_low", done, 0);
          got++;
          seen = 1'b0;
          hs_edge = cyc + 1;
          if (got == NEURONS && poke) start = 1'b1;
        end
      end else begin
        if (seen) begin
          chk("valid_held", out_valid, 1);
          seen = 1'b0;
        end
        out_ready = 1'($urandom_range(0, 1));
      end
      tick();
      cyc++;
    end
    if (got < NEURONS) chk("timeout_results", got, NEURONS);
    start = 1'b0;
    out_ready = 1'b0;
    chk("done_pulse", {29'd0, done, busy, out_valid}, 32'd4);
    tick();
    chk("after_done", {30'd0, done, busy}, 32'd0);
    chk("done_count", done_cnt - d0, 1);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    load_directed(1'b0);
    repeat (3) tick();
    chk("rst_status", {28'd0, busy, done, mac_clr, out_valid}, 32'd0);
    chk("rst_out", {out_data, 15'd0, out_idx}, 32'd0);
    chk("rst_addr", {x_addr, w_addr}, 32'd0);
    chk("rst_mac", {mac_x, mac_w}, 32'd0);
    rst = 1'b0;
    tick();

    // Directed: 10 / 3 (15 / 0 with bias)
    run_pass(0, 1'b0, 1'b0);
    // Backpressure on row 0
    run_pass(5, 1'b0, 1'b0);
    // start while busy and on final handshake edge
    run_pass(0, 1'b1, 1'b1);
    // Saturation passthrough
    load_directed(1'b1);
    run_pass(0, 1'b0, 1'b0);

    // Reset in row 1 at STREAM i=2
    load_directed(1'b0);
    begin
      int d0;
      d0 = done_cnt;
      start = 1'b1;
      tick();
      start = 1'b0;
      out_ready = 1'b1;
      repeat (10 + 2 * EXTRA) tick();
      chk("mid_x_addr", x_addr, 2);
      chk("mid_w_addr", w_addr, SIZE + 2);
      chk("mid_busy", busy, 1);
      #2 rst = 1'b1;
      #1;
      chk("rst_async", {28'd0, busy, out_valid, mac_clr, done}, 32'd0);
      tick();
      rst = 1'b0;
      out_ready = 1'b0;
      tick();
      chk("rst_no_done", done_cnt - d0, 0);
      chk("rst_idle", busy, 0);
    end
    run_pass(0, 1'b0, 1'b0);

    // Randomized passes
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < SIZE; i++) x_mem[i] = rand_val();
      for (int i = 0; i < SIZE * NEURONS; i++) w_mem[i] = rand_val();
      for (int n = 0; n < NEURONS; n++) b_mem[n] = rand_val();
      repeat ($urandom_range(0, 3)) tick();
      run_pass(int'($urandom_range(0, 4)), 1'b1, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
